// File: rtl/microwave_pkg.sv
// Shared types and key-code constants for the cook-time entry path.
package microwave_pkg;

    typedef logic [3:0] bcd_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ENTRY  = 2'd1,
        ST_LOADED = 2'd2
    } state_e;

    localparam logic [3:0] KEY_START     = 4'hA;
    localparam logic [3:0] KEY_CANCEL    = 4'hB;
    localparam logic [3:0] KEY_DIGIT_MAX = 4'd9;
    localparam logic [2:0] DIGITS_MAX    = 3'd4;

    function automatic logic is_digit(input logic [3:0] code);
        return code <= KEY_DIGIT_MAX;
    endfunction

endpackage

// File: rtl/pgt_edge_detect.sv
// Rising-edge detector on the encoder strobe: one key_evt per pgt high period, zero latency.
// pgt_q resets high so a key already held when reset is applied never produces an event.
module pgt_edge_detect (
    input  logic clk,
    input  logic clear,
    input  logic pgt,
    output logic key_evt
);

    logic pgt_q;

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            pgt_q <= 1'b1;
        end else begin
            pgt_q <= pgt;
        end
    end

    assign key_evt = pgt & ~pgt_q;

endmodule

// File: rtl/time_entry_decoder.sv
// Assembles keypad digits into an MM:SS entry and issues a one-cycle load on START.
// Outputs update on the edge that first sees pgt high; no backpressure, the timer must accept load.
module time_entry_decoder
    import microwave_pkg::*;
#(
    parameter logic [3:0] START_CODE   = KEY_START,
    parameter logic [3:0] CANCEL_CODE  = KEY_CANCEL,
    parameter logic [3:0] MAX_SEC_TENS = 4'd5
) (
    input  logic       clk,
    input  logic       clear,
    input  logic [3:0] key_code,
    input  logic       pgt,
    input  logic       timer_done,
    output bcd_t       min_tens,
    output bcd_t       min_units,
    output bcd_t       sec_tens,
    output bcd_t       sec_units,
    output logic [2:0] digit_count,
    output logic       load,
    output logic       busy,
    output logic       entry_err
);

    logic   key_evt;
    state_e state_q, state_d;
    bcd_t   min_tens_d, min_units_d, sec_tens_d, sec_units_d;
    logic [2:0] count_d;
    logic   load_d, err_d;

    pgt_edge_detect u_edge (
        .clk     (clk),
        .clear   (clear),
        .pgt     (pgt),
        .key_evt (key_evt)
    );

    always_comb begin
        state_d     = state_q;
        min_tens_d  = min_tens;
        min_units_d = min_units;
        sec_tens_d  = sec_tens;
        sec_units_d = sec_units;
        count_d     = digit_count;
        load_d      = 1'b0;
        err_d       = 1'b0;

        // timer_done outranks any key arriving in the same cycle
        if (timer_done && state_q == ST_LOADED) begin
            state_d     = ST_IDLE;
            min_tens_d  = '0;
            min_units_d = '0;
            sec_tens_d  = '0;
            sec_units_d = '0;
            count_d     = '0;
        end else if (key_evt) begin
            if (key_code == CANCEL_CODE) begin
                state_d     = ST_IDLE;
                min_tens_d  = '0;
                min_units_d = '0;
                sec_tens_d  = '0;
                sec_units_d = '0;
                count_d     = '0;
            end else if (key_code == START_CODE) begin
                case (state_q)
                    ST_IDLE: err_d = 1'b1;
                    ST_ENTRY: begin
                        if (sec_tens > MAX_SEC_TENS) begin
                            err_d = 1'b1;
                        end else begin
                            load_d  = 1'b1;
                            state_d = ST_LOADED;
                        end
                    end
                    default: ;
                endcase
            end else if (is_digit(key_code)) begin
                if (state_q == ST_LOADED) begin
                    err_d = 1'b1;
                end else begin
                    min_tens_d  = min_units;
                    min_units_d = sec_tens;
                    sec_tens_d  = sec_units;
                    sec_units_d = key_code;
                    count_d     = (digit_count == DIGITS_MAX) ? DIGITS_MAX : digit_count + 3'd1;
                    state_d     = ST_ENTRY;
                end
            end else begin
                err_d = 1'b1;
            end
        end

        if (!(state_q inside {ST_IDLE, ST_ENTRY, ST_LOADED})) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q     <= ST_IDLE;
            min_tens    <= '0;
            min_units   <= '0;
            sec_tens    <= '0;
            sec_units   <= '0;
            digit_count <= '0;
            load        <= 1'b0;
            entry_err   <= 1'b0;
        end else begin
            state_q     <= state_d;
            min_tens    <= min_tens_d;
            min_units   <= min_units_d;
            sec_tens    <= sec_tens_d;
            sec_units   <= sec_units_d;
            digit_count <= count_d;
            load        <= load_d;
            entry_err   <= err_d;
        end
    end

    assign busy = (state_q == ST_LOADED);

endmodule

// File: doc/time_entry_decoder.md
Name: time_entry_decoder

Overview:
Receiving end of the keypad encoder. Takes the encoder's 4-bit key code and its debounced valid strobe `pgt`, and assembles digit keys into a 4-digit MM:SS cook-time entry. It also interprets the START and CANCEL codes and issues a one-cycle load to the cook timer. It sits between the encoder and the countdown timer/display path.

Parameters:
START_CODE, 4'hA, key code meaning "start/load"
CANCEL_CODE, 4'hB, key code meaning "cancel/clear entry"
MAX_SEC_TENS, 5, largest legal seconds-tens digit accepted at START

Ports:
clk  in  1  system clock, rising edge
clear  in  1  asynchronous, active-high reset
key_code  in  4  key code from encoder; valid while pgt high
pgt  in  1  encoder key-valid strobe; high for many cycles per key press
timer_done  in  1  countdown timer finished or aborted; one-cycle pulse
min_tens  out  4  BCD minutes tens
min_units  out  4  BCD minutes units
sec_tens  out  4  BCD seconds tens
sec_units  out  4  BCD seconds units
digit_count  out  3  digits entered, saturates at 4
load  out  1  one-cycle pulse; digit outputs are the time to load
busy  out  1  high in LOADED state
entry_err  out  1  one-cycle pulse on a rejected key

Behaviour:
- Reset (clear=1, async):
  - All digit outputs 0; digit_count 0.
  - load, entry_err, busy all 0.
  - State IDLE.
  - pgt_q is set to 1, so a key held across reset is not registered.
- Key event:
  - key_evt = pgt & ~pgt_q, with pgt_q a registered copy of pgt.
  - Exactly one event per pgt high period, regardless of its length.
  - key_code is sampled on the same edge.
  - Outputs change at that same clock edge, i.e. latency is one edge after pgt is first seen high.
- Digit key (code 0–9), in IDLE or ENTRY:
  - Shift left: min_tens<=min_units, min_units<=sec_tens, sec_tens<=sec_units, sec_units<=code.
  - The 5th and later digits discard the oldest digit. digit_count saturates at 4.
  - Go to ENTRY.
- Codes 0xC–0xF, or any digit key in LOADED: entry_err pulse, no other change.
- START key:
  - In IDLE (no digits): entry_err, stay IDLE.
  - In ENTRY with sec_tens <= MAX_SEC_TENS: load pulse for 1 cycle, go to LOADED, digits held.
  - In ENTRY with sec_tens > MAX_SEC_TENS: entry_err, stay ENTRY, digits kept.
  - In LOADED: ignored, no error.
- CANCEL key, any state: digits and digit_count cleared, go to IDLE.
  - No load pulse. busy drops on the next edge.
- LOADED:
  - busy=1.
  - timer_done=1 → digits cleared, digit_count 0, go to IDLE.
- Simultaneous events:
  - timer_done together with a key_evt in LOADED: timer_done wins, and the key is dropped.
  - CANCEL together with timer_done: result is IDLE either way.
- State encoding: IDLE, ENTRY, LOADED.
  - Unreachable encodings return to IDLE.
- Pulse exclusivity: load and entry_err are never high in the same cycle.
- Reset mid-LOADED: immediate IDLE. The load is not re-issued.

Decomposition:
- Shared package `microwave_pkg`:
  - State enum (IDLE/ENTRY/LOADED).
  - Key-code constants: START, CANCEL, digit range limit 9.
  - A BCD digit typedef (4 bits).
- One natural sub-module: `pgt_edge_detect`, which holds the pgt_q register (reset to 1) and produces key_evt.

Test Plan:
- Reset, then keys 1,2,3,0 (pgt high 10 cycles each) → min_tens..sec_units = 1,2,3,0; digit_count=4; exactly 4 updates.
- Keys 1,2,3,4,5 → 2,3,4,5; digit_count=4.
- Keys 1,3,0 then START → load high exactly 1 cycle with 0,1,3,0; busy=1; a following digit 7 gives entry_err and no change; timer_done → all 0, IDLE.
- Keys 1,9,0 then START (sec_tens=9) → entry_err pulse, no load, digits stay 0,1,9,0.
- START from IDLE → entry_err, no load.
- Keys 4,5 then CANCEL → digits 0, digit_count 0.
- pgt held high while clear is pulsed mid-LOADED → outputs 0 immediately; no key event until pgt falls and rises again.
- Code 0xE → entry_err only.
